arch_reg_file: RTL and testbench

- Architectural register file plus rename status table; the other end of the ROB commit and arch-read interfaces.
- Drives `commit_valid` to the ROB and consumes `commit_arch_num`, `commit_tag` and `commit_data` when a commit completes.
- At issue, records the ROB tag of each destination register.
- Supplies two source-register lookups to dispatch, each giving busy, tag and data, so operands are taken either from the architectural value or from the ROB entry named by the tag.

---
 rtl/arch_reg_file_if.sv | 46 ++++
 rtl/arch_reg_file.sv | 124 ++++++++++++
 tb/tb_arch_reg_file.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arch_reg_file_if.sv
// Dispatch / ROB side bundle for arch_reg_file.
// master: the dispatch and ROB logic driving source lookups, issue and commit.
// slave : the architectural register file itself.
interface arch_reg_file_if #(
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
);

  // Two source-operand lookups
  logic [REG_WIDTH-1:0]  read_num  [1:0];
  logic                  read_busy [1:0];
  logic [ROB_WIDTH-1:0]  read_tag  [1:0];
  logic [DATA_WIDTH-1:0] read_data [1:0];

  // Destination rename at issue
  logic                  issue;
  logic                  issue_dst_en;
  logic [REG_WIDTH-1:0]  issue_dst_num;
  logic [ROB_WIDTH-1:0]  issue_tag;

  // Retirement handshake with the ROB head
  logic                  commit_valid;
  logic                  commit_ready;
  logic                  commit_stall;
  logic [REG_WIDTH-1:0]  commit_arch_num;
  logic [ROB_WIDTH-1:0]  commit_tag;
  logic [DATA_WIDTH-1:0] commit_data;

  modport master (
    output read_num,
    input  read_busy, read_tag, read_data,
    output issue, issue_dst_en, issue_dst_num, issue_tag,
    input  commit_valid,
    output commit_ready, commit_stall, commit_arch_num, commit_tag, commit_data
  );

  modport slave (
    input  read_num,
    output read_busy, read_tag, read_data,
    input  issue, issue_dst_en, issue_dst_num, issue_tag,
    output commit_valid,
    input  commit_ready, commit_stall, commit_arch_num, commit_tag, commit_data
  );

endinterface

// File: rtl/arch_reg_file.sv
// Architectural register file with rename status (busy + ROB tag per register).
// Commits from the ROB head write architectural data and clear busy when the
// committing tag is still the newest producer. Issue marks destinations busy.
// Optional feature: define ARF_COMMIT_BYPASS_EN to forward a completing
// commit onto the read ports in the same cycle.
module arch_reg_file #(
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  arch_reg_file_if.slave       bus,
  input  logic                 flush,
  output logic [31:0]          commit_count
);

  localparam int unsigned NUM_REGS = 1 << REG_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [ROB_WIDTH-1:0]  tag_q  [NUM_REGS];
  logic [ROB_WIDTH-1:0]  tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  logic commit_fire;
  logic commit_wr;
  logic issue_fire;

  // Handshake decode: commit completes when not stalled and the head is done
  always_comb begin
    bus.commit_valid = !bus.commit_stall;
    commit_fire      = bus.commit_valid && bus.commit_ready;
    commit_wr        = commit_fire && (bus.commit_arch_num != '0);
    issue_fire       = bus.issue && bus.issue_dst_en &&
                       (bus.issue_dst_num != '0) && !flush;
  end

  // Rename status next state: flush clears busy, issue overrides a same-register commit
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (commit_fire && busy_q[bus.commit_arch_num] &&
          (tag_q[bus.commit_arch_num] == bus.commit_tag)) begin
        busy_d[bus.commit_arch_num] = 1'b0;
      end
      if (issue_fire) begin
        busy_d[bus.issue_dst_num] = 1'b1;
        tag_d[bus.issue_dst_num]  = bus.issue_tag;
      end
    end
  end

  // Rename status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Architectural data: written by every completing commit (including in a flush cycle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
    end else if (commit_wr) begin
      regs_q[bus.commit_arch_num] <= bus.commit_data;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_count <= '0;
    end else if (commit_fire) begin
      commit_count <= commit_count + 32'd1;
    end
  end

  // One source lookup; register 0 reads as idle zero
  function automatic void lookup(
    input  logic [REG_WIDTH-1:0]  num,
    output logic                  busy,
    output logic [ROB_WIDTH-1:0]  tag,
    output logic [DATA_WIDTH-1:0] data
  );
    busy = busy_q[num];
    tag  = tag_q[num];
    data = regs_q[num];
    if (num == '0) begin
      busy = 1'b0;
      data = '0;
    end
`ifdef ARF_COMMIT_BYPASS_EN
    // Forward the completing commit; busy only drops if no same-register issue re-claims it
    if (commit_wr && (num == bus.commit_arch_num)) begin
      data = bus.commit_data;
      if ((tag_q[num] == bus.commit_tag) &&
          !(issue_fire && (bus.issue_dst_num == num))) begin
        busy = 1'b0;
      end
    end
`endif
  endfunction

  // Source-operand read ports
  always_comb begin
    bus.read_busy[0] = 1'b0;
    bus.read_tag[0]  = '0;
    bus.read_data[0] = '0;
    bus.read_busy[1] = 1'b0;
    bus.read_tag[1]  = '0;
    bus.read_data[1] = '0;
    lookup(bus.read_num[0], bus.read_busy[0], bus.read_tag[0], bus.read_data[0]);
    lookup(bus.read_num[1], bus.read_busy[1], bus.read_tag[1], bus.read_data[1]);
  end

endmodule

// File: tb/tb_arch_reg_file.sv
// Self-checking bench for arch_reg_file: table of per-cycle vectors with
// scoreboarded post-edge read expectations, plus hand-written sequences for
// async reset mid-operation and same-cycle commit forwarding.
module tb_arch_reg_file;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic [31:0] commit_count;

  arch_reg_file_if #(.REG_WIDTH(5), .ROB_WIDTH(4), .DATA_WIDTH(32)) bus ();

  arch_reg_file #(.REG_WIDTH(5), .ROB_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .flush        (flush),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iss;
    logic        iss_en;
    logic [4:0]  iss_num;
    logic [3:0]  iss_tag;
    logic        cr;
    logic        cs;
    logic [4:0]  c_num;
    logic [3:0]  c_tag;
    logic [31:0] c_data;
    logic        fl;
    logic [4:0]  rn0;
    logic [4:0]  rn1;
    logic        eb0;
    logic [3:0]  et0;
    logic [31:0] ed0;
    logic        eb1;
    logic [3:0]  et1;
    logic [31:0] ed1;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    logic        eb0;
    logic [3:0]  et0;
    logic [31:0] ed0;
    logic        eb1;
    logic [3:0]  et1;
    logic [31:0] ed1;
    logic [31:0] ecnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(
    input int iss, input int en, input int inum, input int itag,
    input int cr, input int cs, input int cnum, input int ctag, input logic [31:0] cdata,
    input int fl, input int rn0, input int rn1,
    input int b0, input int t0, input logic [31:0] d0,
    input int b1, input int t1, input logic [31:0] d1,
    input int cnt
  );
    vec_t v;
    v.iss = 1'(iss);   v.iss_en = 1'(en);  v.iss_num = 5'(inum); v.iss_tag = 4'(itag);
    v.cr = 1'(cr);     v.cs = 1'(cs);      v.c_num = 5'(cnum);   v.c_tag = 4'(ctag);
    v.c_data = cdata;  v.fl = 1'(fl);
    v.rn0 = 5'(rn0);   v.rn1 = 5'(rn1);
    v.eb0 = 1'(b0);    v.et0 = 4'(t0);     v.ed0 = d0;
    v.eb1 = 1'(b1);    v.et1 = 4'(t1);     v.ed1 = d1;
    v.ecnt = 32'(cnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue           = 1'b0;
    bus.issue_dst_en    = 1'b0;
    bus.issue_dst_num   = '0;
    bus.issue_tag       = '0;
    bus.commit_ready    = 1'b0;
    bus.commit_stall    = 1'b0;
    bus.commit_arch_num = '0;
    bus.commit_tag      = '0;
    bus.commit_data     = '0;
    flush               = 1'b0;
  endtask

  task automatic read_check(input string name, input int port, input logic [4:0] num,
                            input logic eb, input logic [3:0] et, input logic [31:0] ed);
    check({name, "_busy"}, 32'(bus.read_busy[port]), 32'(eb));
    check({name, "_tag"},  32'(bus.read_tag[port]),  32'(et));
    check({name, "_data"}, bus.read_data[port],      ed);
    if (bus.read_num[port] !== num) $display("read_num drive error on port %0d", port);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // iss en inum itag | cr cs cnum ctag cdata | fl | rn0 rn1 | b0 t0 d0 | b1 t1 d1 | cnt
    vecs.push_back(mk(1,1, 3,7, 0,0, 0,0,'h0,    0, 3, 0, 1,7,'h0,    0,0,'h0,    0));
    vecs.push_back(mk(0,0, 0,0, 1,0, 3,7,'h1234, 0, 3, 0, 0,7,'h1234, 0,0,'h0,    1));
    vecs.push_back(mk(1,1, 4,2, 0,0, 0,0,'h0,    0, 4, 3, 1,2,'h0,    0,7,'h1234, 1));
    vecs.push_back(mk(1,1, 4,5, 0,0, 0,0,'h0,    0, 4, 3, 1,5,'h0,    0,7,'h1234, 1));
    vecs.push_back(mk(0,0, 0,0, 1,0, 4,2,'hAA,   0, 4, 3, 1,5,'hAA,   0,7,'h1234, 2));
    vecs.push_back(mk(1,1, 6,9, 1,0, 6,1,'h55,   0, 6, 4, 1,9,'h55,   1,5,'hAA,   3));
    vecs.push_back(mk(1,1, 0,3, 0,0, 0,0,'h0,    0, 0, 6, 0,0,'h0,    1,9,'h55,   3));
    vecs.push_back(mk(0,0, 0,0, 1,1, 3,7,'hFFFF, 0, 3, 6, 0,7,'h1234, 1,9,'h55,   3));
    vecs.push_back(mk(1,0,10,4, 0,0, 0,0,'h0,    0,10, 4, 0,0,'h0,    1,5,'hAA,   3));
    vecs.push_back(mk(1,1, 1,1, 0,0, 0,0,'h0,    0, 1, 2, 1,1,'h0,    0,0,'h0,    3));
    vecs.push_back(mk(1,1, 2,2, 0,0, 0,0,'h0,    0, 1, 2, 1,1,'h0,    1,2,'h0,    3));
    vecs.push_back(mk(1,1, 7,6, 1,0, 5,0,'h99,   1, 1, 7, 0,1,'h0,    0,0,'h0,    4));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,'h0,    0, 2, 5, 0,2,'h0,    0,0,'h99,   4));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,'h0,    0, 4, 6, 0,5,'hAA,   0,9,'h55,   4));
    vecs.push_back(mk(0,0, 0,0, 1,0, 0,0,'hDEAD, 0, 0, 4, 0,0,'h0,    0,5,'hAA,   5));
    vecs.push_back(mk(1,1, 8,3, 0,0, 0,0,'h0,    0, 8, 0, 1,3,'h0,    0,0,'h0,    5));
    vecs.push_back(mk(0,0, 0,0, 0,0, 8,3,'h1,    0, 8, 0, 1,3,'h0,    0,0,'h0,    5));

    // Reset state
    reset_n = 1'b0;
    idle();
    bus.read_num[0] = 5'd5;
    bus.read_num[1] = 5'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    read_check("rst_r5", 0, 5'd5, 1'b0, 4'd0, 32'h0);
    read_check("rst_r0", 1, 5'd0, 1'b0, 4'd0, 32'h0);
    check("rst_count", commit_count, 32'd0);

    // Table-driven cycles; post-edge reads are scoreboarded
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.issue           = vecs[i].iss;
      bus.issue_dst_en    = vecs[i].iss_en;
      bus.issue_dst_num   = vecs[i].iss_num;
      bus.issue_tag       = vecs[i].iss_tag;
      bus.commit_ready    = vecs[i].cr;
      bus.commit_stall    = vecs[i].cs;
      bus.commit_arch_num = vecs[i].c_num;
      bus.commit_tag      = vecs[i].c_tag;
      bus.commit_data     = vecs[i].c_data;
      flush               = vecs[i].fl;
      sb.push_back('{vecs[i].eb0, vecs[i].et0, vecs[i].ed0,
                     vecs[i].eb1, vecs[i].et1, vecs[i].ed1, vecs[i].ecnt});
      #1;
      check($sformatf("v%0d_commit_valid", i), 32'(bus.commit_valid), 32'(!vecs[i].cs));
      @(posedge clk);
      #1;
      idle();
      bus.read_num[0] = vecs[i].rn0;
      bus.read_num[1] = vecs[i].rn1;
      #1;
      e = sb.pop_front();
      read_check($sformatf("v%0d_p0", i), 0, vecs[i].rn0, e.eb0, e.et0, e.ed0);
      read_check($sformatf("v%0d_p1", i), 1, vecs[i].rn1, e.eb1, e.et1, e.ed1);
      check($sformatf("v%0d_count", i), commit_count, e.ecnt);
    end

    // Bring commit_count to 10 with r8 still busy
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.commit_ready    = 1'b1;
      bus.commit_arch_num = 5'd11;
      bus.commit_tag      = 4'd0;
      bus.commit_data     = 32'(k + 'h100);
      @(posedge clk);
      #1;
      idle();
    end
    @(negedge clk);
    bus.read_num[0] = 5'd8;
    bus.read_num[1] = 5'd3;
    #1;
    check("pre_rst_count", commit_count, 32'd10);
    read_check("pre_rst_r8", 0, 5'd8, 1'b1, 4'd3, 32'h0);
    read_check("pre_rst_r3", 1, 5'd3, 1'b0, 4'd7, 32'h1234);

    // Asynchronous reset between edges clears everything immediately
    #1;
    reset_n = 1'b0;
    #1;
    read_check("arst_r8", 0, 5'd8, 1'b0, 4'd0, 32'h0);
    read_check("arst_r3", 1, 5'd3, 1'b0, 4'd0, 32'h0);
    check("arst_count", commit_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Same-cycle commit of a busy source: forwarded only with the bypass build
    @(negedge clk);
    bus.issue         = 1'b1;
    bus.issue_dst_en  = 1'b1;
    bus.issue_dst_num = 5'd9;
    bus.issue_tag     = 4'd4;
    @(posedge clk);
    #1;
    idle();
    bus.read_num[0] = 5'd9;
    bus.read_num[1] = 5'd9;
    #1;
    read_check("byp_pre_r9", 0, 5'd9, 1'b1, 4'd4, 32'h0);
    @(negedge clk);
    bus.commit_ready    = 1'b1;
    bus.commit_arch_num = 5'd9;
    bus.commit_tag      = 4'd4;
    bus.commit_data     = 32'h77;
    #1;
`ifdef ARF_COMMIT_BYPASS_EN
    read_check("byp_same_r9", 1, 5'd9, 1'b0, 4'd4, 32'h77);
`else
    read_check("byp_same_r9", 1, 5'd9, 1'b1, 4'd4, 32'h0);
`endif
    @(posedge clk);
    #1;
    idle();
    #1;
    read_check("byp_post_r9", 0, 5'd9, 1'b0, 4'd4, 32'h77);
    check("byp_post_count", commit_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
